datapath_unit: RTL and testbench

// - Single-cycle 8-bit CPU datapath for the lab board, with 4-instruction ISA: add, lw, sw, j.
// - Divides the board clock into CLK_ and executes one instruction per CLK_ rising edge.
// - Owns PC, a 4x8 register file, a 32x8 data memory and the nibble display outputs m/l.
// - Instruction memory is external: the caller drives `instruction` = imem[PC].

---
 rtl/datapath_unit.sv | 123 ++++++++++++
 tb/tb_datapath_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/datapath_unit.sv
// datapath_unit: single-cycle 8-bit datapath (add/lw/sw/j) for the lab board.
// The board clock _CLK is the only clock; CLK_ is a divided copy and every
// architectural update happens on the _CLK edge that drives CLK_ high.
module datapath_unit #(
    parameter int DIV_HALF = 1
) (
    input  logic       _CLK,
    input  logic       RESET,
    input  logic [7:0] instruction,
    output logic [7:0] PC,
    output logic [3:0] m,
    output logic [3:0] l,
    output logic       CLK_,
    output logic [7:0] address
);

    localparam int CW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_J   = 2'b11;

    logic [CW-1:0] div_cnt;
    logic          div_hit;
    logic          commit;

    logic [7:0] regs [0:3];
    logic [7:0] mem  [0:31];
    logic [7:0] result;

    logic [1:0] op;
    logic [1:0] rs;
    logic [1:0] rt;
    logic [1:0] rd;
    logic [7:0] imm_ext;
    logic [7:0] rs_val;
    logic [7:0] rt_val;
    logic [7:0] sum;
    logic [7:0] ea;
    logic [7:0] jump_pc;
    logic [7:0] load_val;

    assign op      = instruction[7:6];
    assign rs      = instruction[5:4];
    assign rt      = instruction[3:2];
    assign rd      = instruction[1:0];
    assign imm_ext = {{6{instruction[1]}}, instruction[1:0]};

    assign rs_val   = regs[rs];
    assign rt_val   = regs[rt];
    assign sum      = rs_val + rt_val;
    assign ea       = rs_val + imm_ext;
    assign jump_pc  = {PC[7:6], instruction[5:0]};
    assign load_val = mem[ea[4:0]];

    // The commit edge is the divider terminal count while CLK_ is still low.
    assign div_hit = (div_cnt == CW'(DIV_HALF - 1));
    assign commit  = div_hit & ~CLK_;

    assign m = result[7:4];
    assign l = result[3:0];

    // Address bus mux: ALU sum, effective address, or jump target.
    always_comb begin
        address = sum;
        case (op)
            OP_ADD:        address = sum;
            OP_LW, OP_SW:  address = ea;
            OP_J:          address = jump_pc;
            default:       address = sum;
        endcase
    end

    // Clock divider: toggle CLK_ every DIV_HALF board-clock edges.
    always_ff @(posedge _CLK or posedge RESET) begin
        if (RESET) begin
            div_cnt <= '0;
            CLK_    <= 1'b0;
        end else if (div_hit) begin
            div_cnt <= '0;
            CLK_    <= ~CLK_;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Architectural state: PC, register file, display result and data memory.
    always_ff @(posedge _CLK or posedge RESET) begin
        if (RESET) begin
            PC     <= 8'h00;
            result <= 8'h00;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= 8'h00;
            end
            for (int k = 0; k < 32; k++) begin
                mem[k] <= 8'(k);
            end
        end else if (commit) begin
            case (op)
                OP_ADD: begin
                    regs[rd] <= sum;
                    result   <= sum;
                    PC       <= PC + 8'd1;
                end
                OP_LW: begin
                    regs[rt] <= load_val;
                    result   <= load_val;
                    PC       <= PC + 8'd1;
                end
                OP_SW: begin
                    mem[ea[4:0]] <= rt_val;
                    result       <= rt_val;
                    PC           <= PC + 8'd1;
                end
                default: begin
                    PC <= jump_pc;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_unit.sv
// tb_datapath_unit: directed and random programs against an arithmetic model.
module tb_datapath_unit;

    logic       clk_b = 1'b0;
    logic       rst;
    logic [7:0] instr;
    logic [7:0] pc_o;
    logic [3:0] m_o;
    logic [3:0] l_o;
    logic       clk_div;
    logic [7:0] addr_o;

    int total = 0;
    int bad   = 0;
    logic timed_out;

    // reference state, kept as plain integers
    int r_reg [4];
    int r_mem [32];
    int r_pc;
    int r_res;
    int imm_tab [4] = '{0, 1, -2, -1};
    int prog [6]    = '{'h71, 'h4D, 'h74, 'hB7, 'h05, 'hC2};

    datapath_unit dut (
        ._CLK        (clk_b),
        .RESET       (rst),
        .instruction (instr),
        .PC          (pc_o),
        .m           (m_o),
        .l           (l_o),
        .CLK_        (clk_div),
        .address     (addr_o)
    );

    always #10 clk_b = ~clk_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) r_reg[i] = 0;
        for (int k = 0; k < 32; k++) r_mem[k] = k;
        r_pc  = 0;
        r_res = 0;
    endtask

    function automatic int model_addr(input int ins);
        int op = ins / 64;
        int rs = (ins / 16) % 4;
        int rt = (ins / 4) % 4;
        if (op == 0) return (r_reg[rs] + r_reg[rt]) % 256;
        if (op == 3) return (r_pc / 64) * 64 + (ins % 64);
        return (r_reg[rs] + imm_tab[ins % 4] + 256) % 256;
    endfunction

    task automatic model_step(input int ins);
        int op = ins / 64;
        int rt = (ins / 4) % 4;
        int rd = ins % 4;
        int a  = model_addr(ins);
        case (op)
            0: begin r_reg[rd] = a; r_res = a; end
            1: begin r_reg[rt] = r_mem[a % 32]; r_res = r_reg[rt]; end
            2: begin r_mem[a % 32] = r_reg[rt]; r_res = r_reg[rt]; end
            default: ;
        endcase
        r_pc = (op == 3) ? a : (r_pc + 1) % 256;
    endtask

    task automatic exec(input int ins);
        instr = 8'(ins);
        #1;
        chk("address", {24'h0, addr_o}, 32'(model_addr(ins)));
        timed_out = 1'b0;
        fork
            begin @(posedge clk_div); end
            begin #1000; timed_out = 1'b1; end
        join_any
        disable fork;
        chk("clk_rise_wait", {31'h0, timed_out}, 32'h0);
        #1;
        model_step(ins);
        chk("pc", {24'h0, pc_o}, 32'(r_pc));
        chk("m", {28'h0, m_o}, 32'(r_res / 16));
        chk("l", {28'h0, l_o}, 32'(r_res % 16));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_pc", {24'h0, pc_o}, 32'(r_pc));
        chk("rst_ml", {24'h0, m_o, l_o}, 32'(r_res));
        chk("rst_clk", {31'h0, clk_div}, 32'h0);
        @(posedge clk_b);
        #1;
        chk("rst_hold_clk", {31'h0, clk_div}, 32'h0);
        chk("rst_hold_pc", {24'h0, pc_o}, 32'(r_pc));
        @(negedge clk_b);
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b0;
        instr = 8'h00;
        #3;
        do_reset();

        // divider: CLK_ toggles on each board rising edge; instruction 00 commits on rises
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk_b);
            #1;
            chk("div_clk", {31'h0, clk_div}, 32'(i % 2));
            if (i % 2 == 1) model_step(0);
            chk("div_pc", {24'h0, pc_o}, 32'(r_pc));
        end

        // lab program fetched from imem[PC]
        do_reset();
        for (int s = 0; s < 14; s++) begin
            exec(prog[(r_pc < 6) ? r_pc : 0]);
        end

        // add overflow: r1 doubles from 1 until it wraps to 0
        do_reset();
        exec('h45);
        for (int s = 0; s < 8; s++) exec('h15);
        exec('h43);

        // PC block walk, jump keeps PC[7:6], increment wraps 255 -> 0
        do_reset();
        for (int s = 0; s < 3; s++) begin
            exec('hFF);
            exec('h00);
        end
        exec('hC5);
        chk("pc_c5", {24'h0, pc_o}, 32'hC5);
        exec('hC3);
        chk("pc_c3", {24'h0, pc_o}, 32'hC3);
        exec('hFF);
        exec('h00);
        chk("pc_wrap", {24'h0, pc_o}, 32'h00);

        // randomized instruction stream
        for (int s = 0; s < 300; s++) exec(int'($urandom_range(0, 255)));

        // reset between CLK_ edges restores memory and clears state immediately
        do_reset();
        exec('h45);
        exec('h84);
        exec('h48);
        chk("mem0_written", {24'h0, m_o, l_o}, 32'h01);
        #5;
        rst = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_pc", {24'h0, pc_o}, 32'h00);
        chk("mid_rst_ml", {24'h0, m_o, l_o}, 32'h00);
        chk("mid_rst_clk", {31'h0, clk_div}, 32'h0);
        @(negedge clk_b);
        @(negedge clk_b);
        rst = 1'b0;
        exec('h48);
        chk("mem0_restored", {24'h0, m_o, l_o}, 32'h00);
        exec('h4B);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
